// File: rtl/registerfile_mp.sv
// Multi-port MIPS register file: NUM_RD combinational reads, two writeback ports,
// optional same-cycle bypass, hardwired zero register and a pending-write scoreboard.
module registerfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_reg,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_reg,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_reg,
  input  logic [NUM_RD*ADDR_W-1:0] rd_reg,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  output logic                     any_pend
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              rsv_ok;

  // With a hardwired zero register, any update aimed at r0 is dropped here once.
  assign wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_reg == '0));
  assign wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_reg == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_reg == '0));

  // Reserve wins over a completing write: it belongs to a younger instruction.
  always_comb begin
    pend_nxt = pend;
    for (int r = 0; r < DEPTH; r++) begin
      if (rsv_ok && (rsv_reg == ADDR_W'(r))) begin
        pend_nxt[r] = 1'b1;
      end else if ((wr0_ok && (wr0_reg == ADDR_W'(r))) ||
                   (wr1_ok && (wr1_reg == ADDR_W'(r)))) begin
        pend_nxt[r] = 1'b0;
      end
    end
  end

  // wr1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
      pend <= '0;
    end else begin
      if (wr0_ok) begin
        mem[wr0_reg] <= wr0_data;
      end
      if (wr1_ok) begin
        mem[wr1_reg] <= wr1_data;
      end
      pend <= pend_nxt;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((ZERO_REG != 0) && (rd_reg[i*ADDR_W +: ADDR_W] == '0)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_pend[i]                  = 1'b0;
      end else if ((BYPASS != 0) && wr1_en && (wr1_reg == rd_reg[i*ADDR_W +: ADDR_W])) begin
        rd_data[i*DATA_W +: DATA_W] = wr1_data;
        rd_pend[i]                  = 1'b0;
      end else if ((BYPASS != 0) && wr0_en && (wr0_reg == rd_reg[i*ADDR_W +: ADDR_W])) begin
        rd_data[i*DATA_W +: DATA_W] = wr0_data;
        rd_pend[i]                  = 1'b0;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = mem[rd_reg[i*ADDR_W +: ADDR_W]];
        rd_pend[i]                  = pend[rd_reg[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign any_pend = |pend;

endmodule

// File: tb/tb_registerfile_mp.sv
// Directed bench for registerfile_mp: one bypassing and one non-bypassing instance
// share the same stimulus so both read behaviours are checked side by side.
module tb_registerfile_mp;

  logic        clk;
  logic        rst;
  logic        wr0_en;
  logic [4:0]  wr0_reg;
  logic [31:0] wr0_data;
  logic        wr1_en;
  logic [4:0]  wr1_reg;
  logic [31:0] wr1_data;
  logic        rsv_en;
  logic [4:0]  rsv_reg;
  logic [9:0]  rd_reg;
  logic [63:0] rdb;
  logic [63:0] rdn;
  logic [1:0]  pendb;
  logic [1:0]  pendn;
  logic        anyb;
  logic        anyn;

  int total;
  int bad;
  logic [31:0] exp_q [$];

  registerfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_reg(wr1_reg), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .rd_reg(rd_reg), .rd_data(rdb), .rd_pend(pendb), .any_pend(anyb)
  );

  registerfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_n (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_reg(wr0_reg), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_reg(wr1_reg), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .rd_reg(rd_reg), .rd_data(rdn), .rd_pend(pendn), .any_pend(anyn)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    wr0_en = 1'b0; wr0_reg = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_reg = '0; wr1_data = '0;
    rsv_en = 1'b0; rsv_reg = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    logic [4:0] p0;
    logic [4:0] p1;
    p0 = a0[4:0];
    p1 = a1[4:0];
    rd_reg = {p1, p0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    set_rd(0, 0);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      set_rd(k, 31 - k);
      #1;
      total++;
      if (rdb !== 64'h0 || rdn !== 64'h0) begin
        bad++;
        $display("FAIL reset_data reg=%0d: got b=%h n=%h want 0", k, rdb, rdn);
      end
      total++;
      if (pendb !== 2'b00 || pendn !== 2'b00 || anyb !== 1'b0 || anyn !== 1'b0) begin
        bad++;
        $display("FAIL reset_pend reg=%0d: got %b/%b any %b/%b want 0", k, pendb, pendn, anyb, anyn);
      end
    end
  endtask

  task automatic test_write_readback();
    for (int k = 1; k < 32; k++) begin
      wr0_en = 1'b1; wr0_reg = k[4:0]; wr0_data = k + 1;
      exp_q.push_back(k + 1);
      step();
    end
    idle();
    for (int k = 1; k < 32; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      set_rd(k, 0);
      #1;
      total++;
      if (rdb[31:0] !== e || rdn[31:0] !== e || rdb[63:32] !== 32'h0) begin
        bad++;
        $display("FAIL readback reg=%0d: got b=%h n=%h want %h", k, rdb[31:0], rdn[31:0], e);
      end
    end
    // r0 ignores writes and reserves, and is never bypassed
    wr0_en = 1'b1; wr0_reg = 5'd0; wr0_data = 32'hDEADBEEF;
    wr1_en = 1'b1; wr1_reg = 5'd0; wr1_data = 32'hCAFEF00D;
    rsv_en = 1'b1; rsv_reg = 5'd0;
    set_rd(0, 0);
    #1;
    total++;
    if (rdb !== 64'h0 || pendb !== 2'b00) begin
      bad++;
      $display("FAIL zero_bypass: got %h pend %b want 0", rdb, pendb);
    end
    step();
    idle();
    #1;
    total++;
    if (rdb !== 64'h0 || rdn !== 64'h0 || anyb !== 1'b0 || anyn !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg: got b=%h n=%h any %b/%b want 0", rdb, rdn, anyb, anyn);
    end
  endtask

  task automatic test_collision();
    wr0_en = 1'b1; wr0_reg = 5'd5; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_reg = 5'd5; wr1_data = 32'h22;
    set_rd(5, 6);
    #1;
    total++;
    if (rdb[31:0] !== 32'h22) begin
      bad++;
      $display("FAIL collide_bypass: got %h want 00000022", rdb[31:0]);
    end
    total++;
    if (rdn[31:0] !== 32'h6 || rdn[63:32] !== 32'h7) begin
      bad++;
      $display("FAIL collide_nobypass: got %h want 0000000700000006", rdn);
    end
    step();
    idle();
    #1;
    total++;
    if (rdb[31:0] !== 32'h22 || rdn[31:0] !== 32'h22) begin
      bad++;
      $display("FAIL collide_stored: got b=%h n=%h want 00000022", rdb[31:0], rdn[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_reg = 5'd7;
    set_rd(7, 8);
    #1;
    total++;
    if (pendb !== 2'b00 || anyb !== 1'b0) begin
      bad++;
      $display("FAIL rsv_early: got pend %b any %b want 00/0", pendb, anyb);
    end
    step();
    idle();
    #1;
    total++;
    if (pendb !== 2'b01 || pendn !== 2'b01 || anyb !== 1'b1 || anyn !== 1'b1) begin
      bad++;
      $display("FAIL rsv_pend: got %b/%b any %b/%b want 01/1", pendb, pendn, anyb, anyn);
    end
    wr1_en = 1'b1; wr1_reg = 5'd7; wr1_data = 32'h77;
    #1;
    total++;
    if (pendb[0] !== 1'b0 || rdb[31:0] !== 32'h77 || anyb !== 1'b1) begin
      bad++;
      $display("FAIL wr_bypass_pend: got pend %b data %h any %b want 0/00000077/1", pendb[0], rdb[31:0], anyb);
    end
    total++;
    if (pendn[0] !== 1'b1 || rdn[31:0] !== 32'h8) begin
      bad++;
      $display("FAIL wr_nobypass_pend: got pend %b data %h want 1/00000008", pendn[0], rdn[31:0]);
    end
    step();
    idle();
    #1;
    total++;
    if (anyb !== 1'b0 || anyn !== 1'b0 || pendb !== 2'b00 || rdn[31:0] !== 32'h77) begin
      bad++;
      $display("FAIL pend_clear: got any %b/%b pend %b data %h want 0/0/00/00000077", anyb, anyn, pendb, rdn[31:0]);
    end
  endtask

  task automatic test_rsv_vs_write();
    rsv_en = 1'b1; rsv_reg = 5'd9;
    step();
    wr0_en = 1'b1; wr0_reg = 5'd9; wr0_data = 32'h99;
    set_rd(9, 10);
    #1;
    total++;
    if (rdb[31:0] !== 32'h99 || pendb[0] !== 1'b0 || pendn[0] !== 1'b1) begin
      bad++;
      $display("FAIL rsv_wr_same: got data %h pend %b/%b want 00000099 0/1", rdb[31:0], pendb[0], pendn[0]);
    end
    step();
    idle();
    #1;
    total++;
    if (pendb !== 2'b01 || pendn !== 2'b01 || rdb[31:0] !== 32'h99 || rdn[31:0] !== 32'h99) begin
      bad++;
      $display("FAIL rsv_beats_wr: got pend %b/%b data %h/%h want 01 00000099", pendb, pendn, rdb[31:0], rdn[31:0]);
    end
  endtask

  task automatic test_mid_reset();
    rsv_en = 1'b1; rsv_reg = 5'd3;
    step();
    rsv_reg = 5'd4;
    wr0_en = 1'b1; wr0_reg = 5'd3; wr0_data = 32'h33;
    step();
    idle();
    set_rd(3, 4);
    #1;
    total++;
    if (rdb[31:0] !== 32'h33 || rdb[63:32] !== 32'h5 || pendb !== 2'b10 || pendn !== 2'b10) begin
      bad++;
      $display("FAIL pre_reset: got %h pend %b/%b want 0000000500000033 10", rdb, pendb, pendn);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (rdb !== 64'h0 || rdn !== 64'h0 || pendb !== 2'b00 || pendn !== 2'b00 ||
        anyb !== 1'b0 || anyn !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got b=%h n=%h pend %b/%b any %b/%b want 0", rdb, rdn, pendb, pendn, anyb, anyn);
    end
    wr0_en = 1'b1; wr0_reg = 5'd3; wr0_data = 32'h55;
    rsv_en = 1'b1; rsv_reg = 5'd4;
    step();
    step();
    rst = 1'b0;
    idle();
    #1;
    total++;
    if (rdb !== 64'h0 || rdn !== 64'h0 || pendb !== 2'b00 || anyb !== 1'b0 || anyn !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: got b=%h n=%h pend %b any %b/%b want 0", rdb, rdn, pendb, anyb, anyn);
    end
    set_rd(5, 9);
    #1;
    total++;
    if (rdn !== 64'h0 || pendn !== 2'b00) begin
      bad++;
      $display("FAIL post_reset_other: got %h pend %b want 0", rdn, pendn);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    rd_reg = '0;
    test_reset();
    test_write_readback();
    test_collision();
    test_scoreboard();
    test_rsv_vs_write();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/registerfile_mp.md
# registerfile_mp

Parametrised multi-port register file for the MIPS datapath, the next-generation replacement for the single-write, two-read register file. It provides NUM_RD combinational read ports, two synchronous write ports (ALU writeback and memory writeback), optional write-to-read bypass, a hardwired zero register, and a per-register pending-write scoreboard. Decode uses the scoreboard to stall on load-use and multi-cycle hazards.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only stored contents
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and is never pending

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr0_en  in  1  write port 0 (ALU writeback) enable
- wr0_reg  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 (memory writeback) enable
- wr1_reg  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- rsv_en  in  1  reserve: mark rsv_reg as pending a future write
- rsv_reg  in  ADDR_W  register to reserve
- rd_reg  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  port i reads a register whose value is not yet available
- any_pend  out  1  OR of all pending bits

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus a 2**ADDR_W-bit pending vector.
- Writes: on the rising edge, for each enabled port, mem[wrX_reg] <= wrX_data.
- Same-address collision: when wr0 and wr1 both target the same register, wr1 wins.
- Pending vector, per register r, on each edge:
  - Set when rsv_en && rsv_reg==r.
  - Else cleared when (wr0_en && wr0_reg==r) or (wr1_en && wr1_reg==r).
  - Else held.
  - A reserve beats a write to the same register in the same cycle, because the reserve represents a younger instruction.
- Reads (combinational), per port i with address a:
  - ZERO_REG && a==0: rd_data = 0, rd_pend = 0.
  - BYPASS && wr1_en && wr1_reg==a: rd_data = wr1_data, rd_pend = 0.
  - Else BYPASS && wr0_en && wr0_reg==a: rd_data = wr0_data, rd_pend = 0.
  - Else: rd_data = mem[a], rd_pend = pend[a].
- BYPASS=0: rd_pend = pend[a], with the ZERO_REG override still applied.
- ZERO_REG=1: writes and reserves to register 0 are discarded; mem[0] and pend[0] stay 0.
- ZERO_REG=0: register 0 behaves like any other register.
- Reset: all registers = 0 and all pending bits = 0, asynchronously on assertion.
  - Outputs are valid combinationally from the reset state: rd_data = 0 (or bypassed data if BYPASS), rd_pend = 0, any_pend = 0.
  - Writes and reserves presented while rst is high are ignored.
  - Reset mid-operation discards all stored data and all reservations.

## Timing
- Write latency: data is visible in stored form on the cycle after the edge. With BYPASS=1 it is visible in the same cycle, before the edge.
- Read latency: 0 cycles (combinational from rd_reg, mem, pend and the write ports).
- Reserve takes effect after the edge: rd_pend rises the cycle after rsv_en.
- Pending clears after the edge of the completing write. With BYPASS=1 the reader sees rd_pend=0 and the correct data in the write cycle itself.
- No internal multicycle state: any write-address/reserve pattern is accepted every cycle.

## Test plan
- Reset then read: hold rst=1, then release; read all 32 registers on two ports -> every rd_data=0, rd_pend=0, any_pend=0.
- Write/readback: write reg k = k+1 for k=1..31 via wr0, then read all with wr0_en=0 -> rd_data=k+1; write 0xDEADBEEF to reg 0 -> reads 0 (ZERO_REG=1).
- Collision and bypass: in one cycle set wr0 reg5=0x11 and wr1 reg5=0x22 while reading reg5 -> rd_data=0x22 in that cycle and stored value 0x22 after the edge. Same stimulus with BYPASS=0 -> old value in that cycle, 0x22 after the edge.
- Scoreboard: rsv reg7 -> rd_pend=1 on reads of reg7 from the next cycle. Write reg7=0x77 via wr1 -> rd_pend=0 and rd_data=0x77 in the write cycle (BYPASS=1); any_pend drops after the edge.
- Reserve vs write: rsv reg9 and wr0 reg9=0x99 in the same cycle, with reg9 already pending -> after the edge pend[9]=1 and mem[9]=0x99.
- Mid-operation reset: reserve regs 3/4, write reg3=0x33, pulse rst asynchronously between edges -> outputs immediately show rd_data=0 and rd_pend=0, and nothing is retained after release.
